// File: rtl/elevator_floor_controller_if.sv
// Call/step inputs and car status outputs between the scheduler and its environment.
// The slave side is the floor controller; the master side drives buttons and step ticks.
interface elevator_floor_controller_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] call_req;
  logic                  step_tick;
  logic                  direction;
  logic                  stop;
  logic [FLOOR_W-1:0]    current_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;

  modport master (
    output call_req, step_tick,
    input  direction, stop, current_floor, pending, door_open
  );

  modport slave (
    input  call_req, step_tick,
    output direction, stop, current_floor, pending, door_open
  );
endinterface

// File: rtl/elevator_floor_controller.sv
// Elevator sweep scheduler: latches calls, counts step ticks into floors, holds the door open.
// Latency: one clock from any input to the registered outputs.
// Backpressure: none; step_tick is consumed only while moving and ignored otherwise.
module elevator_floor_controller #(
  parameter int NUM_FLOORS      = 4,
  parameter int FLOOR_W         = 2,
  parameter int STEPS_PER_FLOOR = 4096,
  parameter int STEP_W          = 16,
  parameter int DOOR_CYCLES     = 100000000,
  parameter int DOOR_W          = 27
) (
  input logic                        clock,
  input logic                        reset,
  elevator_floor_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     count_q, count_d;
  logic [DOOR_W-1:0]     timer_q, timer_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, next_floor;
  logic [NUM_FLOORS-1:0] pend_q, pend_d, req;
  logic                  dir_q, dir_d, stop_q, stop_d, door_q, door_d;
  logic                  above, below, ahead;

  // Requests as seen this cycle; a press at the open-door floor only restarts the timer.
  always_comb begin
    req = pend_q | bus.call_req;
    if (state_q == DOOR) req[floor_q] = pend_q[floor_q];
    next_floor = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    above = 1'b0;
    below = 1'b0;
    ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > floor_q) above = above | req[i];
      if (FLOOR_W'(i) < floor_q) below = below | req[i];
      if (dir_q ? (FLOOR_W'(i) > next_floor) : (FLOOR_W'(i) < next_floor)) ahead = ahead | req[i];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    floor_d = floor_q;
    pend_d  = req;
    dir_d   = dir_q;
    stop_d  = stop_q;
    door_d  = door_q;
    case (state_q)
      IDLE: begin
        if (req[floor_q]) begin
          state_d         = DOOR;
          pend_d[floor_q] = 1'b0;
          timer_d         = '0;
          door_d          = 1'b1;
          stop_d          = 1'b1;
        end else if (|req) begin
          // Keep sweeping if anything lies ahead, else turn around.
          state_d = MOVE;
          stop_d  = 1'b0;
          count_d = '0;
          dir_d   = dir_q ? above : ~below;
        end
      end
      MOVE: begin
        if (bus.step_tick) begin
          if (count_q == STEP_W'(STEPS_PER_FLOOR - 1)) begin
            count_d = '0;
            floor_d = next_floor;
            if (req[next_floor]) begin
              state_d            = DOOR;
              stop_d             = 1'b1;
              door_d             = 1'b1;
              timer_d            = '0;
              pend_d[next_floor] = 1'b0;
            end else if (!ahead) begin
              state_d = IDLE;
              stop_d  = 1'b1;
            end
          end else begin
            count_d = count_q + STEP_W'(1);
          end
        end
      end
      DOOR: begin
        if (bus.call_req[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_W'(DOOR_CYCLES - 1)) begin
          state_d = IDLE;
          door_d  = 1'b0;
        end else begin
          timer_d = timer_q + DOOR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stop_d  = 1'b1;
        door_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
      floor_q <= '0;
      pend_q  <= '0;
      dir_q   <= 1'b1;
      stop_q  <= 1'b1;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      floor_q <= floor_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      stop_q  <= stop_d;
      door_q  <= door_d;
    end
  end

  assign bus.direction     = dir_q;
  assign bus.stop          = stop_q;
  assign bus.door_open     = door_q;
  assign bus.current_floor = floor_q;
  assign bus.pending       = pend_q;
endmodule

// File: tb/tb_elevator_floor_controller.sv
// Scenario bench for the elevator scheduler with a position-in-steps reference model.
module tb_elevator_floor_controller;
  localparam int NF = 4, FW = 2, S = 4, SW = 4, D = 10, DW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  elevator_floor_controller_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_floor_controller #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .STEPS_PER_FLOOR(S), .STEP_W(SW),
    .DOOR_CYCLES(D), .DOOR_W(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: mode 0 idle, 1 moving, 2 door; position kept as an absolute step count.
  int          m_mode, m_pos, m_fl, m_el;
  logic        m_dir;
  logic [NF-1:0] m_pend;

  function automatic logic [8:0] dut_vec();
    return {bus.direction, bus.stop, bus.door_open, bus.current_floor, bus.pending};
  endfunction

  function automatic logic [8:0] mdl_vec();
    return {m_dir, (m_mode != 1), (m_mode == 2), FW'(m_fl), m_pend};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_fl = 0; m_el = 0; m_dir = 1'b1; m_pend = '0;
  endtask

  task automatic model_step(input logic [NF-1:0] c, input logic t);
    logic [NF-1:0] req;
    logic above, below, ahead;
    req = m_pend | c;
    if (m_mode == 2) req[m_fl] = m_pend[m_fl];
    above = 1'b0; below = 1'b0; ahead = 1'b0;
    for (int j = 0; j < NF; j++) begin
      if (j > m_fl && req[j]) above = 1'b1;
      if (j < m_fl && req[j]) below = 1'b1;
    end
    case (m_mode)
      0: begin
        if (req[m_fl]) begin
          m_mode = 2; m_el = 0; req[m_fl] = 1'b0;
        end else if (req != 0) begin
          m_mode = 1;
          if (m_dir) m_dir = above ? 1'b1 : 1'b0;
          else       m_dir = below ? 1'b0 : 1'b1;
        end
      end
      1: begin
        if (t) begin
          m_pos = m_pos + (m_dir ? 1 : -1);
          if (m_pos % S == 0) begin
            m_fl = m_pos / S;
            if (req[m_fl]) begin
              m_mode = 2; m_el = 0; req[m_fl] = 1'b0;
            end else begin
              for (int j = 0; j < NF; j++)
                if ((m_dir ? (j > m_fl) : (j < m_fl)) && req[j]) ahead = 1'b1;
              if (!ahead) m_mode = 0;
            end
          end
        end
      end
      default: begin
        if (c[m_fl])          m_el = 0;
        else if (m_el == D-1) m_mode = 0;
        else                  m_el++;
      end
    endcase
    m_pend = req;
  endtask

  task automatic cyc(input logic [NF-1:0] c, input logic t);
    bus.call_req  = c;
    bus.step_tick = t;
    @(posedge clock);
    model_step(c, t);
    #1;
    bus.call_req  = '0;
    bus.step_tick = 1'b0;
  endtask

  task automatic settle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_mode == 0 && m_pend == 0) break;
      cyc('0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec())
        $display("FAIL settle: got %b want %b", dut_vec(), mdl_vec());
      if (dut_vec() !== mdl_vec()) errors++;
    end
    checks++;
    if ({bus.stop, bus.door_open, bus.pending} !== 6'b10_0000) begin
      errors++;
      $display("FAIL settle_idle: got stop/door/pend %b want 100000", {bus.stop, bus.door_open, bus.pending});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.call_req = '0; bus.step_tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (dut_vec() !== 9'b1_1_0_00_0000) begin
      errors++; $display("FAIL reset_vals: got %b want 110000000", dut_vec());
    end
    @(negedge clock) reset = 1'b1;
    cyc('0, 1'b1);
    checks++;
    if (dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL reset_idle: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_local_call();
    cyc(4'b0001, 1'b0);
    checks++;
    if ({bus.door_open, bus.stop, bus.pending, bus.current_floor} !== 8'b11_0000_00) begin
      errors++; $display("FAIL local_open: got %b want 11000000", {bus.door_open, bus.stop, bus.pending, bus.current_floor});
    end
    for (int i = 0; i < D-1; i++) begin
      cyc('0, 1'($urandom_range(0, 1)));
      checks++;
      if (bus.door_open !== 1'b1 || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL local_hold%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    cyc('0, 1'b0);
    checks++;
    if ({bus.door_open, bus.stop, bus.current_floor} !== 4'b0100) begin
      errors++; $display("FAIL local_close: got %b want 0100", {bus.door_open, bus.stop, bus.current_floor});
    end
  endtask

  task automatic test_sweep_up();
    cyc(4'b1000, 1'b0);
    checks++;
    if ({bus.direction, bus.stop} !== 2'b10) begin
      errors++; $display("FAIL sweep_start: got dir/stop %b want 10", {bus.direction, bus.stop});
    end
    for (int k = 1; k <= 12; k++) begin
      cyc('0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec() || bus.current_floor !== FW'(k / S)) begin
        errors++; $display("FAIL sweep_tick%0d: got %b want %b floor %0d", k, dut_vec(), mdl_vec(), k / S);
      end
    end
    checks++;
    if ({bus.stop, bus.door_open, bus.current_floor, bus.pending} !== 8'b11_11_0000) begin
      errors++; $display("FAIL sweep_arrive: got %b want 11110000", {bus.stop, bus.door_open, bus.current_floor, bus.pending});
    end
    settle(D + 2);
  endtask

  task automatic test_reverse();
    cyc(4'b0001, 1'b0);
    checks++;
    if ({bus.direction, bus.stop} !== 2'b00) begin
      errors++; $display("FAIL rev_turn: got dir/stop %b want 00", {bus.direction, bus.stop});
    end
    repeat (S + 2) cyc('0, 1'b1);
    cyc(4'b0100, 1'b0);
    for (int k = 0; k < S + 2; k++) begin
      cyc('0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL rev_down%0d: got %b want %b", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if ({bus.door_open, bus.current_floor, bus.pending} !== 7'b1_00_0100) begin
      errors++; $display("FAIL rev_bottom: got %b want 1000100", {bus.door_open, bus.current_floor, bus.pending});
    end
    for (int i = 0; i < 60; i++) begin
      if (m_mode == 2 && m_fl == 2) break;
      cyc('0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL rev_up%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if ({bus.door_open, bus.direction, bus.current_floor, bus.pending} !== 8'b11_10_0000) begin
      errors++; $display("FAIL rev_serve2: got %b want 11100000", {bus.door_open, bus.direction, bus.current_floor, bus.pending});
    end
    settle(D + 2);
  endtask

  task automatic test_same_edge();
    cyc(4'b0001, 1'b0);
    settle(60);
    cyc(4'b1000, 1'b0);
    repeat (S - 1) cyc('0, 1'b1);
    cyc(4'b0010, 1'b1);
    checks++;
    if ({bus.stop, bus.door_open, bus.current_floor, bus.pending} !== 8'b11_01_1000) begin
      errors++; $display("FAIL same_edge: got %b want 11011000", {bus.stop, bus.door_open, bus.current_floor, bus.pending});
    end
    settle(60);
  endtask

  task automatic test_door_repress();
    cyc(4'b0100, 1'b0);
    repeat (S) cyc('0, 1'b1);
    checks++;
    if ({bus.door_open, bus.current_floor} !== 3'b1_10) begin
      errors++; $display("FAIL repress_open: got %b want 110", {bus.door_open, bus.current_floor});
    end
    repeat (7) cyc('0, 1'b0);
    cyc(4'b0100, 1'b0);
    checks++;
    if ({bus.door_open, bus.pending} !== 5'b1_0000) begin
      errors++; $display("FAIL repress_latch: got %b want 10000", {bus.door_open, bus.pending});
    end
    for (int i = 0; i < D-1; i++) begin
      cyc('0, 1'b0);
      checks++;
      if (bus.door_open !== 1'b1) begin
        errors++; $display("FAIL repress_hold%0d: got %b want 1", i, bus.door_open);
      end
    end
    cyc('0, 1'b0);
    checks++;
    if (bus.door_open !== 1'b0 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL repress_close: got %b want %b", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_reset_mid_move();
    cyc(4'b0001, 1'b0);
    repeat (S + 2) cyc('0, 1'b1);
    checks++;
    if ({bus.stop, bus.current_floor} !== 3'b0_01) begin
      errors++; $display("FAIL midmove_pos: got %b want 001", {bus.stop, bus.current_floor});
    end
    @(negedge clock) reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 9'b1_1_0_00_0000) begin
      errors++; $display("FAIL midmove_reset: got %b want 110000000", dut_vec());
    end
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 2 * S; i++) begin
      cyc('0, 1'b1);
      checks++;
      if (dut_vec() !== mdl_vec() || bus.stop !== 1'b1) begin
        errors++; $display("FAIL midmove_ignore%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [NF-1:0] c;
    for (int i = 0; i < 2000; i++) begin
      c = '0;
      if ($urandom_range(0, 11) == 0) c = NF'($urandom_range(1, 15));
      cyc(c, 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL random%0d: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    settle(200);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_local_call();
    test_sweep_up();
    test_reverse();
    test_same_edge();
    test_door_repress();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
